req_encoder_32x5: RTL and testbench

- Sequential 32-to-5 encoder; the inverse of the team's 5x32 decoder.
- Accepts a 32-bit request vector through a valid/ready handshake.
- Emits the 5-bit index of every set bit, one index per accepted output beat, lowest index first.
- Sits between request-generating logic and any consumer that drives a 5x32 decoder with the returned index.

---
 rtl/req_enc_pkg.sv | 14 +
 rtl/first_set_finder.sv | 31 +++
 rtl/req_encoder_32x5.sv | 98 +++++++++
 tb/tb_req_encoder_32x5.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/req_enc_pkg.sv
// rtl/req_enc_pkg.sv - shared constants, state and index types for the 32-to-5 request encoder
package req_enc_pkg;

    localparam int N_IN  = 32;
    localparam int IDX_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/first_set_finder.sv
// rtl/first_set_finder.sv - combinational first-set-bit finder; direction set by REQ_ENC_MSB_FIRST_EN
module first_set_finder
    import req_enc_pkg::*;
(
    input  logic [N_IN-1:0] vec_i,
    output idx_t            idx_o,
    output logic            any_o,
    output logic            single_o
);

    localparam logic [N_IN-1:0] ONE = {{(N_IN-1){1'b0}}, 1'b1};

    // Priority scan: the last match written wins, so loop order sets the served end.
    always_comb begin
        idx_o = '0;
`ifdef REQ_ENC_MSB_FIRST_EN
        for (int k = 0; k < N_IN; k++) begin
            if (vec_i[k]) idx_o = idx_t'(k);
        end
`else
        for (int k = N_IN - 1; k >= 0; k--) begin
            if (vec_i[k]) idx_o = idx_t'(k);
        end
`endif
    end

    assign any_o    = |vec_i;
    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign single_o = any_o && ((vec_i & (vec_i - ONE)) == '0);

endmodule

// File: rtl/req_encoder_32x5.sv
// rtl/req_encoder_32x5.sv - sequential 32-to-5 encoder, one index per beat; optional REQ_ENC_MSB_FIRST_EN
module req_encoder_32x5
    import req_enc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_req,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic            out_last,
    output logic            none,
    output logic            busy
);

    localparam logic [N_IN-1:0] ONE = {{(N_IN-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [N_IN-1:0] pend_q, pend_d;
    logic            rdy_q, rdy_d;
    logic            none_q, none_d;

    idx_t            pend_idx;
    logic            pend_any;
    logic            pend_single;

    first_set_finder u_finder (
        .vec_i    (pend_q),
        .idx_o    (pend_idx),
        .any_o    (pend_any),
        .single_o (pend_single)
    );

    // State, pending vector, ready flag and empty-vector pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            rdy_q   <= 1'b0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            rdy_q   <= rdy_d;
            none_q  <= none_d;
        end
    end

    // Next-state: capture in IDLE, retire one bit per accepted beat in SCAN.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        rdy_d   = rdy_q;
        none_d  = 1'b0;
        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (in_valid && rdy_q) begin
                    pend_d = in_req;
                    if (in_req != '0) begin
                        state_d = SCAN;
                        rdy_d   = 1'b0;
                    end else begin
                        none_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                rdy_d = 1'b0;
                if (!pend_any) begin
                    // Unreachable in normal operation; recovers rather than emitting a bogus index.
                    state_d = IDLE;
                    rdy_d   = 1'b1;
                end else if (out_ready) begin
                    pend_d = pend_q & ~(ONE << pend_idx);
                    if (pend_single) begin
                        state_d = IDLE;
                        rdy_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q == SCAN);
    assign busy      = (state_q == SCAN);
    assign out_idx   = pend_idx;
    assign out_last  = (state_q == SCAN) && pend_single;
    assign none      = none_q;

endmodule

// File: tb/tb_req_encoder_32x5.sv
// tb/tb_req_encoder_32x5.sv - randomized self-checking bench for req_encoder_32x5 (REQ_ENC_MSB_FIRST_EN aware)
module tb_req_encoder_32x5;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_req;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        none;
    logic        busy;

    int checks;
    int errors;

    req_encoder_32x5 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_req    (in_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .none      (none),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected index order: every set bit, ascending (or descending in the MSB-first build).
    function automatic void build_expect(input logic [31:0] vec, output int q[$]);
        q = {};
        for (int k = 0; k < 32; k++) begin
            if (vec[k]) begin
`ifdef REQ_ENC_MSB_FIRST_EN
                q.push_front(k);
`else
                q.push_back(k);
`endif
            end
        end
    endfunction

    // mode 0: out_ready always high; 1: random; 2: low for the first 3 cycles.
    task automatic serialise(input logic [31:0] vec, input int mode, input string name);
        int q[$];
        int n;
        int cyc;
        build_expect(vec, q);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait in_ready=%b required=1", name, in_ready);
            return;
        end
        in_valid = 1'b1;
        in_req   = vec;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_req   = $urandom;
        if (q.size() == 0) begin
            checks++;
            if (none !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s zero_accept none=%b out_valid=%b in_ready=%b busy=%b required 1 0 1 0",
                         name, none, out_valid, in_ready, busy);
            end
            @(posedge clk); #1;
            checks++;
            if (none !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s none_pulse none=%b out_valid=%b required 0 0", name, none, out_valid);
            end
            return;
        end
        cyc = 0;
        while (q.size() > 0 && cyc < 300) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc >= 3);
            endcase
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 ||
                out_idx !== 5'(q[0]) || out_last !== (q.size() == 1)) begin
                errors++;
                $display("FAIL %s beat cyc=%0d valid=%b busy=%b in_ready=%b idx=%0d last=%b required 1 1 0 idx=%0d last=%b",
                         name, cyc, out_valid, busy, in_ready, out_idx, out_last, q[0], (q.size() == 1));
            end
            @(posedge clk); #1;
            if (out_ready) void'(q.pop_front());
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s end left=%0d out_valid=%b busy=%b in_ready=%b required 0 0 0 1",
                     name, q.size(), out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_idx !== 5'd0 || out_last !== 1'b0 || none !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values valid=%b idx=%0d last=%b none=%b busy=%b in_ready=%b required all 0",
                     out_valid, out_idx, out_last, none, busy, in_ready);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early in_ready=%b required=0", in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        serialise(32'h0000_0001, 0, "single_bit0");
        serialise(32'h8000_0000, 0, "single_bit31");
    endtask

    task automatic test_three_bits();
        serialise(32'h8000_0011, 0, "three_bits");
    endtask

    task automatic test_zero();
        serialise(32'h0000_0000, 0, "zero_vector");
    endtask

    task automatic test_stall();
        serialise(32'h0000_0300, 2, "stall");
    endtask

    task automatic test_reset_mid_scan();
        int q[$];
        build_expect(32'hFFFF_FFFF, q);
        in_valid  = 1'b1;
        in_req    = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 5'(q[b])) begin
                errors++;
                $display("FAIL mid_reset_pre beat=%0d valid=%b idx=%0d required 1 idx=%0d", b, out_valid, out_idx, q[b]);
            end
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async valid=%b busy=%b in_ready=%b last=%b required 0 0 0 0",
                     out_valid, busy, in_ready, out_last);
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_release in_ready=%b valid=%b required 1 0", in_ready, out_valid);
        end
        serialise(32'h0000_0004, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        serialise(32'hFFFF_FFFF, 0, "all_ones");
        serialise(32'h0000_0000, 0, "b2b_zero");
        serialise(32'h4000_0002, 0, "b2b_two");
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0:       v = 32'h0;
                1:       v = 32'h1 << $urandom_range(0, 31);
                2:       v = $urandom & $urandom & $urandom;
                default: v = $urandom;
            endcase
            serialise(v, 1, "random");
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_req    = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_three_bits();
        test_zero();
        test_stall();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
